// File: rtl/smbus_echo_monitor_if.sv
// Purpose: bundles the LTPI receive-side frame stream, the local transmit
//          notification and the monitor's event/echo outputs into one port.
// Latency: n/a (wiring only); no backpressure, every strobe is a one-cycle event.
// Ports (slave = monitor side):
//   in : rx_link_up, rx_frm_valid, rx_event[3:0], tx_evt_load, tx_event[3:0]
//   out: evt_valid, evt_code[3:0], echo_ok, echo_err, retry_req, retry_event[3:0], fail
interface smbus_echo_monitor_if;
    logic       rx_link_up;
    logic       rx_frm_valid;
    logic [3:0] rx_event;
    logic       tx_evt_load;
    logic [3:0] tx_event;
    logic       evt_valid;
    logic [3:0] evt_code;
    logic       echo_ok;
    logic       echo_err;
    logic       retry_req;
    logic [3:0] retry_event;
    logic       fail;

    modport slave (
        input  rx_link_up, rx_frm_valid, rx_event, tx_evt_load, tx_event,
        output evt_valid, evt_code, echo_ok, echo_err, retry_req, retry_event, fail
    );

    modport master (
        output rx_link_up, rx_frm_valid, rx_event, tx_evt_load, tx_event,
        input  evt_valid, evt_code, echo_ok, echo_err, retry_req, retry_event, fail
    );
endinterface

// File: rtl/smbus_echo_monitor.sv
// Purpose: receive-side SMBus event monitor for the LTPI mgmt path; dedups remote
//          events and tracks the echo expected for the last locally sent event.
// Latency: every output registered, pulses appear 1 clk after the causing strobe;
//          no backpressure, one frame per rx_frm_valid strobe is always consumed.
// Ports: clk, reset (sync, active-high), bus (smbus_echo_monitor_if.slave).
// Optional: define SMBUS_ECHO_MON_STATS_EN to add stat_ok_cnt, stat_retry_cnt,
//           stat_fail_cnt (16-bit saturating, cleared only by reset).
// smbus_event_t encoding: 0 idle, 1 start, 2 data_0, 3 data_1, 4 bit_rcv, 5 stop,
//   8 start_echo, 9 data_0_echo, 10 data_1_echo, 11 data_rcv_echo, 12 stop_echo.
module smbus_echo_monitor #(
    parameter int TIMEOUT_FRAMES = 8,
    parameter int MAX_RETRY      = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    smbus_echo_monitor_if.slave        bus
`ifdef SMBUS_ECHO_MON_STATS_EN
    ,
    output logic [15:0]                stat_ok_cnt,
    output logic [15:0]                stat_retry_cnt,
    output logic [15:0]                stat_fail_cnt
`endif
);
    localparam logic [3:0] EV_IDLE      = 4'd0;
    localparam logic [3:0] EV_START     = 4'd1;
    localparam logic [3:0] EV_DATA_0    = 4'd2;
    localparam logic [3:0] EV_DATA_1    = 4'd3;
    localparam logic [3:0] EV_BIT_RCV   = 4'd4;
    localparam logic [3:0] EV_STOP      = 4'd5;
    localparam logic [3:0] EV_START_E   = 4'd8;
    localparam logic [3:0] EV_DATA_0_E  = 4'd9;
    localparam logic [3:0] EV_DATA_1_E  = 4'd10;
    localparam logic [3:0] EV_RCV_E     = 4'd11;
    localparam logic [3:0] EV_STOP_E    = 4'd12;

    localparam int FW = ($clog2(TIMEOUT_FRAMES + 1) > 4) ? $clog2(TIMEOUT_FRAMES + 1) : 4;
    localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FAIL} state_t;

    state_t          state_q;
    logic [3:0]      last_rx_q;
    logic [3:0]      exp_q;
    logic [FW-1:0]   frm_cnt_q;
    logic [FW-1:0]   frm_cnt_d;
    logic [RW-1:0]   retry_cnt_q;
    logic            evt_valid_q;
    logic [3:0]      evt_code_q;
    logic            echo_ok_q;
    logic            echo_err_q;
    logic            retry_req_q;
    logic [3:0]      retry_event_q;
    logic            fail_q;

    logic            rx_is_echo;
    logic            rx_is_new;
    logic            tx_has_echo;
    logic [3:0]      tx_exp;

    always_comb begin
        rx_is_echo = (bus.rx_event >= EV_START_E) && (bus.rx_event <= EV_STOP_E);
        // Only a change of code reports; an idle frame in between re-arms the report.
        rx_is_new  = (bus.rx_event != last_rx_q) && (bus.rx_event != EV_IDLE) && !rx_is_echo;
        frm_cnt_d  = frm_cnt_q + FW'(1);
    end

    always_comb begin
        tx_has_echo = 1'b0;
        tx_exp      = EV_IDLE;
        case (bus.tx_event)
            EV_START:   begin tx_has_echo = 1'b1; tx_exp = EV_START_E;  end
            EV_DATA_0:  begin tx_has_echo = 1'b1; tx_exp = EV_DATA_0_E; end
            EV_DATA_1:  begin tx_has_echo = 1'b1; tx_exp = EV_DATA_1_E; end
            EV_BIT_RCV: begin tx_has_echo = 1'b1; tx_exp = EV_RCV_E;    end
            EV_STOP:    begin tx_has_echo = 1'b1; tx_exp = EV_STOP_E;   end
            default:    begin tx_has_echo = 1'b0; tx_exp = EV_IDLE;     end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            last_rx_q     <= EV_IDLE;
            exp_q         <= EV_IDLE;
            frm_cnt_q     <= '0;
            retry_cnt_q   <= '0;
            evt_valid_q   <= 1'b0;
            evt_code_q    <= EV_IDLE;
            echo_ok_q     <= 1'b0;
            echo_err_q    <= 1'b0;
            retry_req_q   <= 1'b0;
            retry_event_q <= EV_IDLE;
            fail_q        <= 1'b0;
        end else begin
            evt_valid_q <= 1'b0;
            echo_ok_q   <= 1'b0;
            echo_err_q  <= 1'b0;
            retry_req_q <= 1'b0;
            if (!bus.rx_link_up) begin
                // Link loss flushes everything except the held output codes.
                state_q     <= S_IDLE;
                last_rx_q   <= EV_IDLE;
                frm_cnt_q   <= '0;
                retry_cnt_q <= '0;
                fail_q      <= 1'b0;
            end else begin
                if (bus.rx_frm_valid) begin
                    last_rx_q <= bus.rx_event;
                    if (rx_is_new) begin
                        evt_valid_q <= 1'b1;
                        evt_code_q  <= bus.rx_event;
                    end
                end
                // A load takes priority: a coincident frame only feeds dedup above.
                if (bus.tx_evt_load) begin
                    fail_q        <= 1'b0;
                    retry_cnt_q   <= '0;
                    frm_cnt_q     <= '0;
                    retry_event_q <= bus.tx_event;
                    exp_q         <= tx_exp;
                    state_q       <= tx_has_echo ? S_WAIT : S_IDLE;
                end else if (state_q == S_WAIT && bus.rx_frm_valid) begin
                    if (bus.rx_event == exp_q) begin
                        echo_ok_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        echo_err_q <= rx_is_echo;
                        if (frm_cnt_d == FW'(TIMEOUT_FRAMES)) begin
                            frm_cnt_q <= '0;
                            if (retry_cnt_q < RW'(MAX_RETRY)) begin
                                retry_req_q <= 1'b1;
                                retry_cnt_q <= retry_cnt_q + RW'(1);
                            end else begin
                                fail_q  <= 1'b1;
                                state_q <= S_FAIL;
                            end
                        end else begin
                            frm_cnt_q <= frm_cnt_d;
                        end
                    end
                end
            end
        end
    end

    assign bus.evt_valid   = evt_valid_q;
    assign bus.evt_code    = evt_code_q;
    assign bus.echo_ok     = echo_ok_q;
    assign bus.echo_err    = echo_err_q;
    assign bus.retry_req   = retry_req_q;
    assign bus.retry_event = retry_event_q;
    assign bus.fail        = fail_q;

`ifdef SMBUS_ECHO_MON_STATS_EN
    logic [15:0] stat_ok_q;
    logic [15:0] stat_retry_q;
    logic [15:0] stat_fail_q;
    logic        fail_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_ok_q    <= '0;
            stat_retry_q <= '0;
            stat_fail_q  <= '0;
            fail_prev_q  <= 1'b0;
        end else begin
            fail_prev_q <= fail_q;
            if (echo_ok_q && stat_ok_q != 16'hFFFF)
                stat_ok_q <= stat_ok_q + 16'd1;
            if (retry_req_q && stat_retry_q != 16'hFFFF)
                stat_retry_q <= stat_retry_q + 16'd1;
            if (fail_q && !fail_prev_q && stat_fail_q != 16'hFFFF)
                stat_fail_q <= stat_fail_q + 16'd1;
        end
    end

    assign stat_ok_cnt    = stat_ok_q;
    assign stat_retry_cnt = stat_retry_q;
    assign stat_fail_cnt  = stat_fail_q;
`endif
endmodule
